// File: rtl/serdes_stream_checker.sv
// Lock-step checker for a serdes link: pops one received and one expected word
// together, compares them, counts words/errors, captures the first mismatch, and times out stalls.
module serdes_stream_checker #(
  parameter int HUB_FIFO_WIDTH = 32,
  parameter int COUNT_WIDTH    = 16,
  parameter int ERR_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [COUNT_WIDTH-1:0]    expected_words,
  input  logic [HUB_FIFO_WIDTH-1:0] rx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  input  logic [HUB_FIFO_WIDTH-1:0] exp_data,
  input  logic                      exp_valid,
  output logic                      exp_ready,
  output logic [COUNT_WIDTH-1:0]    word_count,
  output logic [ERR_WIDTH-1:0]      error_count,
  output logic                      first_err_valid,
  output logic [COUNT_WIDTH-1:0]    first_err_index,
  output logic [HUB_FIFO_WIDTH-1:0] first_err_rx,
  output logic [HUB_FIFO_WIDTH-1:0] first_err_exp,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout,
  output logic                      pass
);

  localparam int STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TIMEOUT} state_t;

  state_t                    r_state;
  logic [COUNT_WIDTH-1:0]    r_word_count;
  logic [COUNT_WIDTH-1:0]    r_exp_words;
  logic [ERR_WIDTH-1:0]      r_err_count;
  logic [STALL_W-1:0]        r_stall;
  logic                      r_fe_valid;
  logic [COUNT_WIDTH-1:0]    r_fe_index;
  logic [HUB_FIFO_WIDTH-1:0] r_fe_rx;
  logic [HUB_FIFO_WIDTH-1:0] r_fe_exp;

  logic                      w_run_ok;
  logic                      w_xfer;
  logic                      w_mismatch;
  logic                      w_last;
  logic                      w_stall_hit;
  logic [COUNT_WIDTH-1:0]    w_wc_nxt;
  logic [STALL_W-1:0]        w_stall_nxt;

  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
    return (&v) ? v : v + ERR_WIDTH'(1);
  endfunction

  // Join handshake: each ready depends only on the opposite valid, so a word
  // is never popped from one side alone.
  assign w_run_ok    = (r_state == S_RUN) && enable && !clear;
  assign rx_ready    = w_run_ok && exp_valid;
  assign exp_ready   = w_run_ok && rx_valid;
  assign w_xfer      = w_run_ok && rx_valid && exp_valid;
  assign w_mismatch  = (rx_data != exp_data);
  assign w_wc_nxt    = r_word_count + COUNT_WIDTH'(1);
  assign w_last      = (r_exp_words != '0) && (w_wc_nxt == r_exp_words);
  assign w_stall_nxt = r_stall + STALL_W'(1);
  assign w_stall_hit = (TIMEOUT_CYCLES != 0) && (w_stall_nxt == STALL_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_word_count <= '0;
      r_exp_words  <= '0;
      r_err_count  <= '0;
      r_stall      <= '0;
      r_fe_valid   <= 1'b0;
      r_fe_index   <= '0;
      r_fe_rx      <= '0;
      r_fe_exp     <= '0;
    end else if (clear) begin
      r_word_count <= '0;
      r_err_count  <= '0;
      r_stall      <= '0;
      r_fe_valid   <= 1'b0;
      r_fe_index   <= '0;
      r_fe_rx      <= '0;
      r_fe_exp     <= '0;
      if (r_state == S_DONE || r_state == S_TIMEOUT) r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state      <= S_RUN;
            r_exp_words  <= expected_words;
            r_word_count <= '0;
            r_err_count  <= '0;
            r_stall      <= '0;
            r_fe_valid   <= 1'b0;
            r_fe_index   <= '0;
            r_fe_rx      <= '0;
            r_fe_exp     <= '0;
          end
        end
        S_RUN: begin
          if (!enable) begin
            r_state <= S_IDLE;
          end else if (w_xfer) begin
            // A transfer always beats the watchdog in the same cycle.
            r_word_count <= w_wc_nxt;
            r_stall      <= '0;
            if (w_mismatch) begin
              r_err_count <= sat_inc(r_err_count);
              if (!r_fe_valid) begin
                r_fe_valid <= 1'b1;
                r_fe_index <= r_word_count;
                r_fe_rx    <= rx_data;
                r_fe_exp   <= exp_data;
              end
            end
            if (w_last) r_state <= S_DONE;
          end else begin
            r_stall <= w_stall_nxt;
            if (w_stall_hit) r_state <= S_TIMEOUT;
          end
        end
        S_DONE, S_TIMEOUT: begin
          if (!enable) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign word_count      = r_word_count;
  assign error_count     = r_err_count;
  assign first_err_valid = r_fe_valid;
  assign first_err_index = r_fe_index;
  assign first_err_rx    = r_fe_rx;
  assign first_err_exp   = r_fe_exp;
  assign busy            = (r_state == S_RUN);
  assign done            = (r_state == S_DONE);
  assign timeout         = (r_state == S_TIMEOUT);
  assign pass            = (r_state == S_DONE) && (r_err_count == '0);

endmodule

// File: doc/serdes_stream_checker.md
# serdes_stream_checker

Self-checking consumer for the hub FIFO serializer/deserializer path. It accepts reconstructed wide words from a deserializer-side FIFO and expected words from a reference FIFO, and consumes one word from each in lock-step. It compares every pair, counts words and mismatches, captures the first mismatch, and flags stalls with a watchdog. It sits at the receiving end of serdes links, both in benches and as an on-chip link self-test.

## Interface
- HUB_FIFO_WIDTH, 32, width of compared words
- COUNT_WIDTH, 16, width of word count, expected count and first-error index
- ERR_WIDTH, 16, width of the saturating error counter
- TIMEOUT_CYCLES, 1024, stall cycles in RUN before timeout; 0 disables the watchdog
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  asynchronous, active-low; asserting it forces every register to its reset value immediately
- enable  in  1  level; starts a check from IDLE and aborts when low
- clear  in  1  synchronous; zeroes all counters and capture registers
- expected_words  in  COUNT_WIDTH  words per run; 0 means run until enable drops
- rx_data  in  HUB_FIFO_WIDTH  received word
- rx_valid  in  1  received word available
- rx_ready  out  1  received word consumed this cycle
- exp_data  in  HUB_FIFO_WIDTH  expected word
- exp_valid  in  1  expected word available
- exp_ready  out  1  expected word consumed this cycle
- word_count  out  COUNT_WIDTH  pairs compared in this run
- error_count  out  ERR_WIDTH  mismatching pairs; saturates at all-ones
- first_err_valid  out  1  a mismatch has been captured
- first_err_index  out  COUNT_WIDTH  word_count value at the first mismatch
- first_err_rx  out  HUB_FIFO_WIDTH  received word at the first mismatch
- first_err_exp  out  HUB_FIFO_WIDTH  expected word at the first mismatch
- busy  out  1  state is RUN
- done  out  1  state is DONE
- timeout  out  1  state is TIMEOUT
- pass  out  1  done and error_count == 0

## Operation
- FSM states: IDLE, RUN, DONE, TIMEOUT. Reset state is IDLE.
- IDLE: rx_ready = exp_ready = 0. If enable = 1, go to RUN and zero word_count, error_count, the stall counter and all first_err_* registers on the same edge.
- RUN: join handshake. rx_ready = exp_valid and exp_ready = rx_valid. A transfer occurs when rx_valid and exp_valid are both 1; both words are popped together. A word is never consumed from one side alone.
- On a transfer:
  - word_count increments. It wraps modulo 2^COUNT_WIDTH when expected_words = 0.
  - If rx_data != exp_data: error_count increments unless it is all-ones. If first_err_valid = 0, capture index = pre-increment word_count, both data words, and set first_err_valid.
  - The stall counter resets.
- Stall counter: increments on each RUN cycle without a transfer. When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0), go to TIMEOUT.
- End of run: if expected_words != 0 and the transfer makes word_count + 1 == expected_words, go to DONE. This is checked before the stall counter; a transfer always wins.
- enable low in RUN: go to IDLE with no transfer that cycle. Counters hold.
- DONE and TIMEOUT: both readies are 0 and results hold. enable low returns to IDLE. A new run needs enable to go low and then high again.
- clear = 1 in any state:
  - zeroes word_count, error_count, the stall counter and first_err_*;
  - from DONE or TIMEOUT it forces IDLE;
  - in RUN it discards any transfer that cycle (both readies held 0) and stays in RUN;
  - it has priority over enable and over transfers.
- expected_words is sampled only on the IDLE to RUN edge. Changes during a run are ignored.

## Timing
- Reset values: rx_ready = exp_ready = 0; word_count = error_count = 0; first_err_valid = 0; first_err_index/rx/exp = 0; busy = done = timeout = pass = 0.
- rx_ready and exp_ready are combinational from state, clear and the opposite valid. There is no combinational path from a valid to its own ready.
- Counters and capture registers update on the edge ending the transfer cycle and are visible the following cycle.
- done/pass assert in the cycle after the final transfer.
- timeout asserts in the cycle after the TIMEOUT_CYCLES-th consecutive stall cycle.
- busy asserts the cycle after enable is sampled high in IDLE.
- Throughput: one pair per cycle when both sides are valid.
- Reset asserted mid-run: immediate return to all reset values. Words in flight are not consumed afterwards.

## Test plan
- Matched stream: 16 identical pairs (12345678, 9abcdef0, 11223344, ...), expected_words = 16, both valid every cycle. Required: 16 transfers in 16 consecutive cycles; word_count = 16, error_count = 0, done = pass = 1 one cycle after the last transfer.
- Single mismatch: rx word 5 = 55667789, expected = 55667788, expected_words = 16. Required: error_count = 1, first_err_index = 5, first_err_rx = 55667789, first_err_exp = 55667788, pass = 0, done = 1.
- Skewed valids: rx_valid bursts of 1-in-8 cycles, exp_valid always high, 8 words. Required: exp_ready is high only in cycles where rx_valid is high; no word is popped from one side alone; word_count = 8.
- Watchdog: TIMEOUT_CYCLES = 20, 3 transfers, then rx_valid held 0. Required: timeout = 1 exactly 21 cycles after the last transfer; word_count = 3; both readies 0 thereafter.
- Reset and clear mid-run: assert reset at word 7 of 16. Required: all outputs return to reset values immediately. Then run 4 pairs, pulse clear with both valids high. Required: no transfer that cycle, word_count = 0, busy stays 1.
- Saturation: ERR_WIDTH = 2, 6 mismatching pairs. Required: error_count sticks at 3; first_err_index = 0.
